// File: rtl/cpu_axi_pkg.sv
// Shared types and constants for the CPU-side AXI read path.
// Provides the read FSM state, requester owner encoding and AXI id/burst constants.
package cpu_axi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        AR,
        R,
        RET
    } axi_rd_state_t;

    typedef enum logic [1:0] {
        ICACHE,
        DCACHE,
        UNCACHE
    } rd_owner_t;

    localparam logic [3:0] AXI_ID_ICACHE  = 4'd0;
    localparam logic [3:0] AXI_ID_DCACHE  = 4'd1;
    localparam logic [3:0] AXI_ID_UNCACHE = 4'd2;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_WORD  = 3'd2;

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter: one-hot grant, search starts after the last winner.
// Ports: clk, reset (async, high), req_i[2:0], update_i (commit grant), grant_o[2:0].
module rr_arbiter3 (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req_i,
    input  logic       update_i,
    output logic [2:0] grant_o
);

    logic [1:0] last_q;
    logic [1:0] last_d;

    // Reset value 2 makes requester 0 the first one searched.
    always_comb begin
        grant_o = 3'b000;
        case (last_q)
            2'd0: begin
                if (req_i[1])      grant_o = 3'b010;
                else if (req_i[2]) grant_o = 3'b100;
                else if (req_i[0]) grant_o = 3'b001;
            end
            2'd1: begin
                if (req_i[2])      grant_o = 3'b100;
                else if (req_i[0]) grant_o = 3'b001;
                else if (req_i[1]) grant_o = 3'b010;
            end
            default: begin
                if (req_i[0])      grant_o = 3'b001;
                else if (req_i[1]) grant_o = 3'b010;
                else if (req_i[2]) grant_o = 3'b100;
            end
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (update_i) begin
            if (grant_o[0])      last_d = 2'd0;
            else if (grant_o[1]) last_d = 2'd1;
            else if (grant_o[2]) last_d = 2'd2;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) last_q <= 2'd2;
        else       last_q <= last_d;
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI AR/R pair between ICache fill, DCache fill and uncached reads.
// Ports: icache_*/dcache_*/uncache_* requester sides, AXI AR/R master, clk, reset.
module axi_rd_arbiter
    import cpu_axi_pkg::*;
#(
    parameter int unsigned LINE_BEATS = 4
) (
    input  logic         clk,
    input  logic         reset,

    input  logic         icache_req,
    input  logic         icache_uncache,
    input  logic [31:0]  icache_addr,
    output logic         icache_addr_ready,
    output logic         icache_data_ready,
    output logic [127:0] icache_rdata,

    input  logic         dcache_rd_req,
    input  logic [31:0]  dcache_rd_addr,
    output logic         dcache_rd_rdy,
    output logic         dcache_ret_valid,
    output logic [127:0] dcache_ret_data,

    input  logic         uncache_rd_req,
    input  logic [2:0]   uncache_rd_size,
    input  logic [31:0]  uncache_rd_addr,
    output logic         uncache_rd_rdy,
    output logic         uncache_ret_valid,
    output logic [31:0]  uncache_ret_data,

    output logic [3:0]   arid,
    output logic [31:0]  araddr,
    output logic [7:0]   arlen,
    output logic [2:0]   arsize,
    output logic [1:0]   arburst,
    output logic         arvalid,
    input  logic         arready,

    input  logic [3:0]   rid,
    input  logic [31:0]  rdata,
    input  logic [1:0]   rresp,
    input  logic         rlast,
    input  logic         rvalid,
    output logic         rready
);

    localparam logic [2:0] BEATS    = 3'(LINE_BEATS);
    localparam logic [7:0] LEN_LINE = 8'(LINE_BEATS - 1);

    axi_rd_state_t state_q, state_d;
    rd_owner_t     owner_q, owner_d;

    logic [31:0]  araddr_q, araddr_d;
    logic [7:0]   arlen_q, arlen_d;
    logic [2:0]   arsize_q, arsize_d;
    logic [3:0]   arid_q, arid_d;
    logic [1:0]   arburst_q, arburst_d;
    logic [2:0]   beat_q, beat_d;
    logic [2:0]   lim_q, lim_d;
    logic [127:0] line_q, line_d;
    logic [127:0] ic_data_q, ic_data_d;
    logic [127:0] dc_data_q, dc_data_d;
    logic [31:0]  uc_data_q, uc_data_d;

    logic [2:0] req_vec;
    logic [2:0] grant;
    logic       arb_update;
    logic       ar_hs;
    logic       beat_ok;
    logic       unused_rresp;

    assign unused_rresp = ^rresp;

    assign req_vec    = {uncache_rd_req, dcache_rd_req, icache_req};
    assign arb_update = (state_q == IDLE) && (|req_vec);
    assign ar_hs      = (state_q == AR) && arready;
    // Beats tagged for another id are dropped entirely.
    assign beat_ok    = (state_q == R) && rvalid && (rid == arid_q);

    rr_arbiter3 u_arb (
        .clk      (clk),
        .reset    (reset),
        .req_i    (req_vec),
        .update_i (arb_update),
        .grant_o  (grant)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arsize_d  = arsize_q;
        arid_d    = arid_q;
        arburst_d = arburst_q;
        beat_d    = beat_q;
        lim_d     = lim_q;
        line_d    = line_q;
        ic_data_d = ic_data_q;
        dc_data_d = dc_data_q;
        uc_data_d = uc_data_q;

        unique case (state_q)
            IDLE: begin
                if (|req_vec) begin
                    state_d   = AR;
                    beat_d    = 3'd0;
                    line_d    = '0;
                    arburst_d = AXI_BURST_INCR;
                    arsize_d  = AXI_SIZE_WORD;
                    unique case (1'b1)
                        grant[0]: begin
                            owner_d = ICACHE;
                            arid_d  = AXI_ID_ICACHE;
                            if (icache_uncache) begin
                                araddr_d = icache_addr;
                                arlen_d  = 8'd0;
                                lim_d    = 3'd1;
                            end else begin
                                araddr_d = {icache_addr[31:4], 4'h0};
                                arlen_d  = LEN_LINE;
                                lim_d    = BEATS;
                            end
                        end
                        grant[1]: begin
                            owner_d  = DCACHE;
                            arid_d   = AXI_ID_DCACHE;
                            araddr_d = {dcache_rd_addr[31:4], 4'h0};
                            arlen_d  = LEN_LINE;
                            lim_d    = BEATS;
                        end
                        grant[2]: begin
                            owner_d  = UNCACHE;
                            arid_d   = AXI_ID_UNCACHE;
                            araddr_d = uncache_rd_addr;
                            arlen_d  = 8'd0;
                            arsize_d = uncache_rd_size;
                            lim_d    = 3'd1;
                        end
                        default: ;
                    endcase
                end
            end
            AR: begin
                if (arready) state_d = R;
            end
            R: begin
                if (beat_ok) begin
                    // Surplus beats are dropped; only rlast ends the burst.
                    if (beat_q < lim_q) begin
                        line_d[{beat_q[1:0], 5'b0} +: 32] = rdata;
                        beat_d = beat_q + 3'd1;
                    end
                    if (rlast) begin
                        state_d = RET;
                        unique case (owner_q)
                            ICACHE:  ic_data_d = line_d;
                            DCACHE:  dc_data_d = line_d;
                            default: uc_data_d = line_d[31:0];
                        endcase
                    end
                end
            end
            RET: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= ICACHE;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            arid_q    <= '0;
            arburst_q <= '0;
            beat_q    <= '0;
            lim_q     <= '0;
            line_q    <= '0;
            ic_data_q <= '0;
            dc_data_q <= '0;
            uc_data_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arsize_q  <= arsize_d;
            arid_q    <= arid_d;
            arburst_q <= arburst_d;
            beat_q    <= beat_d;
            lim_q     <= lim_d;
            line_q    <= line_d;
            ic_data_q <= ic_data_d;
            dc_data_q <= dc_data_d;
            uc_data_q <= uc_data_d;
        end
    end

    assign arvalid = (state_q == AR);
    assign araddr  = araddr_q;
    assign arlen   = arlen_q;
    assign arsize  = arsize_q;
    assign arid    = arid_q;
    assign arburst = arburst_q;
    assign rready  = (state_q == R);

    assign icache_addr_ready = ar_hs && (owner_q == ICACHE);
    assign dcache_rd_rdy     = ar_hs && (owner_q == DCACHE);
    assign uncache_rd_rdy    = ar_hs && (owner_q == UNCACHE);

    assign icache_data_ready = (state_q == RET) && (owner_q == ICACHE);
    assign dcache_ret_valid  = (state_q == RET) && (owner_q == DCACHE);
    assign uncache_ret_valid = (state_q == RET) && (owner_q == UNCACHE);

    assign icache_rdata     = ic_data_q;
    assign dcache_ret_data  = dc_data_q;
    assign uncache_ret_data = uc_data_q;

    a_rid_match: assert property (@(posedge clk) disable iff (reset)
        (state_q == R && rvalid) |-> (rid == arid_q))
        else $warning("R beat rid %0d dropped, owner id %0d", rid, arid_q);

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: bench acts as requesters and AXI slave.
// A transaction-level model predicts grant order, AR fields, line data and pulse timing.
module tb_axi_rd_arbiter;

    localparam int LB = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         icache_req, icache_uncache;
    logic [31:0]  icache_addr;
    logic         icache_addr_ready, icache_data_ready;
    logic [127:0] icache_rdata;
    logic         dcache_rd_req;
    logic [31:0]  dcache_rd_addr;
    logic         dcache_rd_rdy, dcache_ret_valid;
    logic [127:0] dcache_ret_data;
    logic         uncache_rd_req;
    logic [2:0]   uncache_rd_size;
    logic [31:0]  uncache_rd_addr;
    logic         uncache_rd_rdy, uncache_ret_valid;
    logic [31:0]  uncache_ret_data;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid, arready;
    logic [3:0]   rid;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast, rvalid, rready;

    axi_rd_arbiter #(.LINE_BEATS(LB)) dut (
        .clk(clk), .reset(reset),
        .icache_req(icache_req), .icache_uncache(icache_uncache),
        .icache_addr(icache_addr), .icache_addr_ready(icache_addr_ready),
        .icache_data_ready(icache_data_ready), .icache_rdata(icache_rdata),
        .dcache_rd_req(dcache_rd_req), .dcache_rd_addr(dcache_rd_addr),
        .dcache_rd_rdy(dcache_rd_rdy), .dcache_ret_valid(dcache_ret_valid),
        .dcache_ret_data(dcache_ret_data),
        .uncache_rd_req(uncache_rd_req), .uncache_rd_size(uncache_rd_size),
        .uncache_rd_addr(uncache_rd_addr), .uncache_rd_rdy(uncache_rd_rdy),
        .uncache_ret_valid(uncache_ret_valid), .uncache_ret_data(uncache_ret_data),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Requester model
    bit           req_on[3];
    logic [31:0]  req_addr[3];
    bit           ic_unc;
    logic [2:0]   uc_size;
    int           rr_last;
    logic [127:0] hold[3];
    bit           seq_mode;

    function automatic logic [31:0] mem(input logic [31:0] a, input int k);
        if (seq_mode) return 32'hA0 + 32'(k);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic int pick();
        for (int i = 1; i <= 3; i++) begin
            int j;
            j = (rr_last + i) % 3;
            if (req_on[j]) return j;
        end
        return -1;
    endfunction

    task automatic drive_reqs();
        icache_req      = req_on[0];
        icache_addr     = req_addr[0];
        icache_uncache  = ic_unc;
        dcache_rd_req   = req_on[1];
        dcache_rd_addr  = req_addr[1];
        uncache_rd_req  = req_on[2];
        uncache_rd_addr = req_addr[2];
        uncache_rd_size = uc_size;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [2:0] pulses();
        return {uncache_ret_valid, dcache_ret_valid, icache_data_ready};
    endfunction

    function automatic logic [2:0] readies();
        return {uncache_rd_rdy, dcache_rd_rdy, icache_addr_ready};
    endfunction

    // Entered at the drive slot of a cycle where the DUT is idle and
    // the requests are visible; that cycle is n = 0.
    task automatic serve(input int who, input int ar_wait, input bit gaps,
                         input bit stray, input int rst_beat,
                         input int exp_lat);
        bit           single, hs, adv, stray_done;
        int           nb, n, k;
        logic [31:0]  ea;
        logic [7:0]   el;
        logic [2:0]   es, one;
        logic [127:0] line;
        single = (who == 2) || (who == 0 && ic_unc);
        nb     = single ? 1 : LB;
        ea     = single ? req_addr[who] : (req_addr[who] & 32'hFFFF_FFF0);
        el     = single ? 8'd0 : 8'(LB - 1);
        es     = (who == 2) ? uc_size : 3'd2;
        one    = 3'(1 << who);
        line   = '0;
        for (int i = 0; i < nb; i++)
            line[32*i +: 32] = mem(ea + 32'(4 * i), i);
        rr_last = who;

        n  = 0;
        hs = 1'b0;
        while (!hs) begin
            hs      = (n == 1 + ar_wait);
            arready = hs;
            #2;
            chk("arvalid", arvalid, n >= 1);
            if (n >= 1) begin
                chk("araddr", araddr, ea);
                chk("arlen", arlen, el);
                chk("arsize", arsize, es);
                chk("arid", arid, 4'(who));
                chk("arburst", arburst, 2'b01);
            end
            chk("ar_rdy", readies(), hs ? one : 3'b000);
            chk("ret_idle", pulses(), 3'b000);
            tick();
            n++;
        end
        arready     = 1'b0;
        req_on[who] = 1'b0;
        drive_reqs();

        k          = 0;
        stray_done = !stray;
        while (k < nb) begin
            if (rst_beat == k) begin
                rvalid = 1'b0;
                rlast  = 1'b0;
                reset  = 1'b1;
                #2;
                chk("rst_arvalid", arvalid, 1'b0);
                chk("rst_rready", rready, 1'b0);
                chk("rst_pulse", pulses(), 3'b000);
                chk("rst_icdata", icache_rdata, 128'h0);
                chk("rst_araddr", araddr, 32'h0);
                for (int i = 0; i < 3; i++) hold[i] = '0;
                rr_last = 2;
                tick();
                reset = 1'b0;
                return;
            end
            rresp = 2'($urandom);
            rvalid = 1'b1;
            rlast  = 1'b0;
            rid    = 4'(who);
            rdata  = $urandom;
            adv    = 1'b0;
            if (!stray_done && k == (nb > 1 ? 1 : 0)) begin
                rid        = (who == 0) ? 4'd1 : 4'd0;
                rdata      = 32'hDEAD_BEEF;
                rlast      = 1'b1;
                stray_done = 1'b1;
            end else if (gaps && $urandom_range(0, 2) == 0) begin
                rvalid = 1'b0;
            end else begin
                rdata = mem(ea + 32'(4 * k), k);
                rlast = (k == nb - 1);
                adv   = 1'b1;
            end
            #2;
            chk("rready", rready, 1'b1);
            chk("ret_busy", pulses(), 3'b000);
            tick();
            n++;
            if (adv) k++;
        end

        rvalid    = 1'b0;
        rlast     = 1'b0;
        hold[who] = line;
        #2;
        chk("ret_pulse", pulses(), one);
        chk("ic_data", icache_rdata, hold[0]);
        chk("dc_data", dcache_ret_data, hold[1]);
        chk("uc_data", uncache_ret_data, hold[2][31:0]);
        chk("rready_off", rready, 1'b0);
        if (exp_lat >= 0) chk("latency", n, exp_lat);
        tick();
    endtask

    task automatic run_pending(input int ar_wait, input bit gaps,
                               input bit stray);
        int w;
        w = pick();
        while (w >= 0) begin
            serve(w, ar_wait, gaps, stray, -1, -1);
            w = pick();
        end
    endtask

    initial begin
        reset   = 1'b1;
        arready = 1'b0;
        rvalid  = 1'b0;
        rlast   = 1'b0;
        rid     = '0;
        rdata   = '0;
        rresp   = '0;
        for (int i = 0; i < 3; i++) begin
            req_on[i]   = 1'b0;
            req_addr[i] = '0;
            hold[i]     = '0;
        end
        ic_unc   = 1'b0;
        uc_size  = 3'd0;
        seq_mode = 1'b0;
        rr_last  = 2;
        drive_reqs();
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        #2;
        chk("rst_arvalid0", arvalid, 1'b0);
        chk("rst_rready0", rready, 1'b0);
        chk("rst_ar0", {arid, araddr, arlen, arsize, arburst}, '0);
        chk("rst_rdy0", readies(), 3'b000);
        chk("rst_ret0", pulses(), 3'b000);
        chk("rst_data0", {icache_rdata, dcache_ret_data[31:0], uncache_ret_data}, '0);
        tick();

        // ICache line fill, minimum latency
        seq_mode    = 1'b1;
        req_on[0]   = 1'b1;
        req_addr[0] = 32'h1FC0_0014;
        ic_unc      = 1'b0;
        drive_reqs();
        serve(0, 0, 1'b0, 1'b0, -1, 6);
        chk("ic_line", icache_rdata,
            128'h000000A3_000000A2_000000A1_000000A0);
        seq_mode = 1'b0;

        // Uncached halfword read
        req_on[2]   = 1'b1;
        req_addr[2] = 32'hBFAF_8002;
        uc_size     = 3'd1;
        drive_reqs();
        serve(2, 0, 1'b0, 1'b0, -1, 3);

        // All three at once
        for (int i = 0; i < 3; i++) begin
            req_on[i]   = 1'b1;
            req_addr[i] = $urandom;
        end
        drive_reqs();
        run_pending(0, 1'b0, 1'b0);

        // arready held low
        req_on[1]   = 1'b1;
        req_addr[1] = $urandom;
        drive_reqs();
        serve(1, 5, 1'b0, 1'b0, -1, -1);

        // rvalid gaps and a stray beat
        req_on[1]   = 1'b1;
        req_addr[1] = $urandom;
        drive_reqs();
        serve(1, 0, 1'b1, 1'b1, -1, -1);

        // Reset during beat 2, then a clean fill
        req_on[0]   = 1'b1;
        req_addr[0] = $urandom;
        drive_reqs();
        serve(0, 0, 1'b0, 1'b0, 2, -1);
        req_on[0]   = 1'b1;
        req_addr[0] = $urandom;
        drive_reqs();
        serve(0, 0, 1'b0, 1'b0, -1, 6);

        // Random traffic
        for (int it = 0; it < 40; it++) begin
            int m, w;
            m = $urandom_range(1, 7);
            for (int i = 0; i < 3; i++) begin
                req_on[i]   = m[i];
                req_addr[i] = $urandom;
            end
            ic_unc  = 1'($urandom);
            uc_size = 3'($urandom_range(0, 2));
            drive_reqs();
            w = pick();
            while (w >= 0) begin
                serve(w, $urandom_range(0, 3), 1'($urandom),
                      1'($urandom), -1, -1);
                w = pick();
            end
        end

        #2;
        chk("final_idle", {arvalid, rready, pulses()}, '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
